// File: rtl/regfile_wb_arb_pkg.sv
// Shared write-back request type, default widths and the x0 index for the
// register-file write-port arbiter.
package regfile_wb_arb_pkg;

  localparam int WB_DATA_WIDTH = 64;
  localparam int WB_RD_WIDTH   = 5;

  localparam logic [WB_RD_WIDTH-1:0] REG_X0 = '0;

  typedef struct packed {
    logic [WB_RD_WIDTH-1:0]   rd;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arb_wb_fifo2.sv
// Two-entry holding FIFO for write-back requests; head visible the cycle after push.
// full_o comes from registered occupancy only, so a push is refused when full even if popping.
module wb_fifo2
  import regfile_wb_arb_pkg::*;
#(
  parameter type T = wb_req_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  T           push_dat_i,
  input  logic       pop_i,
  output T           head_o,
  output logic       full_o,
  output logic [1:0] occ_o
);

  T           mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] occ_q;
  logic       do_push;
  logic       do_pop;

  assign full_o  = (occ_q == 2'd2);
  assign occ_o   = occ_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (occ_q != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Register-file write-port arbiter (ALU vs buffered MDU); ALU lands 1 cycle, MDU 2+ cycles later.
// Stalls ALU only on a forced MDU grant; MDU stalls when its FIFO is full. REGFILE_WB_ARB_STARVE_EN enables the starvation bound.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = WB_DATA_WIDTH,
  parameter int RD_WIDTH     = WB_RD_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_wb_valid,
  output logic                  alu_wb_ready,
  input  logic [RD_WIDTH-1:0]   alu_wb_rd,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  input  logic                  mdu_wb_valid,
  output logic                  mdu_wb_ready,
  input  logic [RD_WIDTH-1:0]   mdu_wb_rd,
  input  logic [DATA_WIDTH-1:0] mdu_wb_data,
  output logic                  rf_we,
  output logic [RD_WIDTH-1:0]   rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [1:0]            mdu_pending
);

  typedef struct packed {
    logic [RD_WIDTH-1:0]   rd;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t                  mdu_req;
  req_t                  head;
  req_t                  win;
  logic                  fifo_full;
  logic [1:0]            occ;
  logic                  h_valid;
  logic                  starve_hit;
  logic                  grant_mdu;
  logic                  grant_alu;
  logic                  rf_we_q,    rf_we_d;
  logic [RD_WIDTH-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  assign mdu_req      = '{rd: mdu_wb_rd, data: mdu_wb_data};
  assign mdu_wb_ready = !fifo_full;
  assign mdu_pending  = occ;
  assign h_valid      = (occ != 2'd0);

  wb_fifo2 #(
    .T (req_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (mdu_wb_valid),
    .push_dat_i (mdu_req),
    .pop_i      (grant_mdu),
    .head_o     (head),
    .full_o     (fifo_full),
    .occ_o      (occ)
  );

`ifdef REGFILE_WB_ARB_STARVE_EN
  logic [2:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = h_valid && (int'(starve_cnt_q) >= STARVE_LIMIT);

  // Counts ALU wins only while an MDU result is waiting; saturates at 7.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_mdu || !h_valid) begin
      starve_cnt_d = 3'd0;
    end else if (grant_alu && (starve_cnt_q != 3'd7)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 3'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;

  assign starve_hit = 1'b0;
`endif

  assign alu_wb_ready = !starve_hit;
  assign grant_alu    = alu_wb_valid && alu_wb_ready;
  assign grant_mdu    = h_valid && (!alu_wb_valid || starve_hit);

  // x0 writes still win the slot and update addr/data, but never raise rf_we.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    win        = '{rd: alu_wb_rd, data: alu_wb_data};
    if (grant_mdu) begin
      win = head;
    end
    if (grant_mdu || grant_alu) begin
      rf_we_d    = (win.rd != RD_WIDTH'(REG_X0));
      rf_waddr_d = win.rd;
      rf_wdata_d = win.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed scenarios plus random traffic against a queue-based
// model of the write port (MDU results wait in order; ALU wins unless the MDU has waited too long).
module tb_regfile_wb_arb;

  localparam int DW    = 64;
  localparam int RW    = 5;
  localparam int LIMIT = 4;
`ifdef REGFILE_WB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_wb_valid = 1'b0;
  logic          alu_wb_ready;
  logic [RW-1:0] alu_wb_rd = '0;
  logic [DW-1:0] alu_wb_data = '0;
  logic          mdu_wb_valid = 1'b0;
  logic          mdu_wb_ready;
  logic [RW-1:0] mdu_wb_rd = '0;
  logic [DW-1:0] mdu_wb_data = '0;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    mdu_pending;

  always #5 clk = ~clk;

  regfile_wb_arb #(
    .DATA_WIDTH   (DW),
    .RD_WIDTH     (RW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .mdu_wb_valid (mdu_wb_valid),
    .mdu_wb_ready (mdu_wb_ready),
    .mdu_wb_rd    (mdu_wb_rd),
    .mdu_wb_data  (mdu_wb_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .mdu_pending  (mdu_pending)
  );

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } item_t;

  item_t         mq[$];
  int            starve;
  logic          exp_we;
  logic [RW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  logic          exp_alu_rdy;
  logic          exp_mdu_rdy;
  bit            alu_acc;
  bit            mdu_acc;
  int            checks = 0;
  int            errors = 0;

  task automatic model_reset();
    mq.delete();
    starve    = 0;
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  task automatic predict();
    exp_mdu_rdy = (mq.size() < 2);
    exp_alu_rdy = !(STARVE_EN && mq.size() != 0 && starve >= LIMIT);
  endtask

  // Advance the model by one cycle using the inputs currently driven, then cross the edge.
  task automatic tick();
    item_t it;
    bit    waiting;
    predict();
    waiting = (mq.size() != 0);
    alu_acc = alu_wb_valid && exp_alu_rdy;
    mdu_acc = mdu_wb_valid && exp_mdu_rdy;
    if (waiting && !alu_acc) begin
      it        = mq.pop_front();
      exp_we    = (it.rd != 0);
      exp_waddr = it.rd;
      exp_wdata = it.data;
      starve    = 0;
    end else if (alu_acc) begin
      exp_we    = (alu_wb_rd != 0);
      exp_waddr = alu_wb_rd;
      exp_wdata = alu_wb_data;
      if (!waiting) starve = 0;
      else if (starve < 7) starve = starve + 1;
    end else begin
      exp_we = 1'b0;
      starve = 0;
    end
    if (mdu_acc) mq.push_back('{rd: mdu_wb_rd, data: mdu_wb_data});
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alu_wb_valid = 1'b0;
    mdu_wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    checks++; if (rf_waddr !== '0) begin errors++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
    checks++; if (rf_wdata !== '0) begin errors++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
    checks++; if (mdu_pending !== 2'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", mdu_pending); end
    checks++; if (mdu_wb_ready !== 1'b1) begin errors++; $display("FAIL reset_mdu_ready got %0b want 1", mdu_wb_ready); end
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready got %0b want 1", alu_wb_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_single();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 64'h1234;
    @(negedge clk);
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL alu1_ready got %0b want 1", alu_wb_ready); end
    tick();
    set_idle();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu1_we got %0b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu1_waddr got %0d want 5", rf_waddr); end
    checks++; if (rf_wdata !== 64'h1234) begin errors++; $display("FAIL alu1_wdata got %h want 1234", rf_wdata); end
    @(negedge clk);
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu1_we_after got %0b want 0", rf_we); end
  endtask

  task automatic test_mdu_single();
    mdu_wb_valid = 1'b1; mdu_wb_rd = 5'd7; mdu_wb_data = 64'hDEAD;
    @(negedge clk);
    checks++; if (mdu_wb_ready !== 1'b1) begin errors++; $display("FAIL mdu1_ready got %0b want 1", mdu_wb_ready); end
    tick();
    set_idle();
    checks++; if (mdu_pending !== 2'd1) begin errors++; $display("FAIL mdu1_pending1 got %0d want 1", mdu_pending); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mdu1_we_early got %0b want 0", rf_we); end
    @(negedge clk);
    tick();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL mdu1_we got %0b want 1", rf_we); end
    checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL mdu1_waddr got %0d want 7", rf_waddr); end
    checks++; if (rf_wdata !== 64'hDEAD) begin errors++; $display("FAIL mdu1_wdata got %h want dead", rf_wdata); end
    checks++; if (mdu_pending !== 2'd0) begin errors++; $display("FAIL mdu1_pending0 got %0d want 0", mdu_pending); end
  endtask

  task automatic test_starvation();
    int mdu_seen = 0;
    int stall_at = -1;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd10; alu_wb_data = 64'h100;
    mdu_wb_valid = 1'b1; mdu_wb_rd = 5'd9;  mdu_wb_data = 64'h9999;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      predict();
      checks++; if (alu_wb_ready !== exp_alu_rdy) begin errors++; $display("FAIL starve_alu_ready c%0d got %0b want %0b", c, alu_wb_ready, exp_alu_rdy); end
      if (alu_wb_ready === 1'b0 && stall_at < 0) stall_at = c;
      tick();
      mdu_wb_valid = 1'b0;
      if (alu_acc) begin alu_wb_rd = alu_wb_rd + 5'd1; alu_wb_data = {$urandom, $urandom}; end
      checks++; if (rf_we !== exp_we) begin errors++; $display("FAIL starve_we c%0d got %0b want %0b", c, rf_we, exp_we); end
      checks++; if (rf_waddr !== exp_waddr) begin errors++; $display("FAIL starve_waddr c%0d got %0d want %0d", c, rf_waddr, exp_waddr); end
      if (rf_we === 1'b1 && rf_waddr === 5'd9) mdu_seen++;
    end
    checks++; if (mdu_seen !== (STARVE_EN ? 1 : 0)) begin errors++; $display("FAIL starve_mdu_writes got %0d want %0d", mdu_seen, STARVE_EN ? 1 : 0); end
    checks++; if (stall_at !== (STARVE_EN ? 5 : -1)) begin errors++; $display("FAIL starve_stall_cycle got %0d want %0d", stall_at, STARVE_EN ? 5 : -1); end
    set_idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tick();
    end
    checks++; if (mdu_pending !== 2'd0) begin errors++; $display("FAIL starve_drain got %0d want 0", mdu_pending); end
  endtask

  task automatic test_fifo_full();
    int k = 0;
    int max_pend = 0;
    int third_at = -1;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd10; alu_wb_data = 64'h55;
    mdu_wb_valid = 1'b1; mdu_wb_rd = 5'd20; mdu_wb_data = 64'hA0;
    for (int c = 0; c < 18; c++) begin
      if (c == 12) alu_wb_valid = 1'b0;
      @(negedge clk);
      predict();
      checks++; if (mdu_wb_ready !== exp_mdu_rdy) begin errors++; $display("FAIL full_mdu_ready c%0d got %0b want %0b", c, mdu_wb_ready, exp_mdu_rdy); end
      checks++; if (alu_wb_ready !== exp_alu_rdy) begin errors++; $display("FAIL full_alu_ready c%0d got %0b want %0b", c, alu_wb_ready, exp_alu_rdy); end
      tick();
      if (mdu_acc) begin
        if (k == 2 && c < 12) third_at = c;
        k++;
      end
      mdu_wb_valid = (k < 3);
      mdu_wb_rd    = 5'(20 + k);
      mdu_wb_data  = 64'(32'hA0 + k);
      if (alu_acc) alu_wb_rd = 5'(10 + (c % 8));
      checks++; if (mdu_pending !== 2'(mq.size())) begin errors++; $display("FAIL full_pending c%0d got %0d want %0d", c, mdu_pending, mq.size()); end
      checks++; if (rf_we !== exp_we || rf_waddr !== exp_waddr) begin errors++; $display("FAIL full_write c%0d got %0b/%0d want %0b/%0d", c, rf_we, rf_waddr, exp_we, exp_waddr); end
      if (int'(mdu_pending) > max_pend) max_pend = int'(mdu_pending);
    end
    checks++; if (max_pend !== 2) begin errors++; $display("FAIL full_max_pending got %0d want 2", max_pend); end
    checks++; if (third_at !== (STARVE_EN ? 6 : -1)) begin errors++; $display("FAIL full_third_accept got %0d want %0d", third_at, STARVE_EN ? 6 : -1); end
    checks++; if (k !== 3 || mdu_pending !== 2'd0) begin errors++; $display("FAIL full_drain got k=%0d pend=%0d want k=3 pend=0", k, mdu_pending); end
    set_idle();
  endtask

  task automatic test_x0();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 64'hFF;
    @(negedge clk);
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %0b want 1", alu_wb_ready); end
    tick();
    set_idle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %0b want 0", rf_we); end
  endtask

  task automatic test_reset_mid();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd11; alu_wb_data = 64'h77;
    for (int c = 0; c < 2; c++) begin
      mdu_wb_valid = 1'b1; mdu_wb_rd = 5'(24 + c); mdu_wb_data = 64'(c + 1);
      @(negedge clk);
      tick();
      alu_wb_rd = 5'(12 + c);
    end
    checks++; if (mdu_pending !== 2'd2 || rf_we !== 1'b1) begin errors++; $display("FAIL rstmid_setup got pend=%0d we=%0b want pend=2 we=1", mdu_pending, rf_we); end
    rst_n = 1'b0;
    set_idle();
    model_reset();
    #1;
    checks++; if (mdu_pending !== 2'd0) begin errors++; $display("FAIL rstmid_pending got %0d want 0", mdu_pending); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got %0b want 0", rf_we); end
    checks++; if (mdu_wb_ready !== 1'b1) begin errors++; $display("FAIL rstmid_mdu_ready got %0b want 1", mdu_wb_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (rf_we !== 1'b0 || mdu_pending !== 2'd0) begin errors++; $display("FAIL rstmid_stale c%0d got we=%0b pend=%0d want 0/0", c, rf_we, mdu_pending); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      alu_wb_valid = ($urandom_range(0, 99) < 60);
      alu_wb_rd    = RW'($urandom_range(0, 31));
      alu_wb_data  = {$urandom, $urandom};
      mdu_wb_valid = ($urandom_range(0, 99) < 40);
      mdu_wb_rd    = RW'($urandom_range(0, 31));
      mdu_wb_data  = {$urandom, $urandom};
      @(negedge clk);
      predict();
      checks++; if (alu_wb_ready !== exp_alu_rdy) begin errors++; $display("FAIL rnd_alu_ready c%0d got %0b want %0b", c, alu_wb_ready, exp_alu_rdy); end
      checks++; if (mdu_wb_ready !== exp_mdu_rdy) begin errors++; $display("FAIL rnd_mdu_ready c%0d got %0b want %0b", c, mdu_wb_ready, exp_mdu_rdy); end
      tick();
      checks++; if (rf_we !== exp_we) begin errors++; $display("FAIL rnd_we c%0d got %0b want %0b", c, rf_we, exp_we); end
      checks++; if (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin errors++; $display("FAIL rnd_addr_data c%0d got %0d/%h want %0d/%h", c, rf_waddr, rf_wdata, exp_waddr, exp_wdata); end
      checks++; if (mdu_pending !== 2'(mq.size())) begin errors++; $display("FAIL rnd_pending c%0d got %0d want %0d", c, mdu_pending, mq.size()); end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_mdu_single();
    test_starvation();
    test_fifo_full();
    test_x0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-back arbiter for the RV64 core's single register-file write port. It shares the port between the in-order ALU/load write-back stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a 2-entry holding FIFO, and a starvation counter bounds MDU wait time. It sits in the datapath between the execute/memory stages and the register file, and drives its write enable, address and data.

## Interface
- DATA_WIDTH, 64, register/data width (32 for RV32 builds)
- RD_WIDTH, 5, register index width
- STARVE_LIMIT, 4, consecutive ALU wins tolerated while an MDU result waits
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- alu_wb_valid  in  1  ALU stage holds a result
- alu_wb_ready  out  1  ALU result accepted this cycle; when low, the pipeline stalls
- alu_wb_rd  in  RD_WIDTH  destination register
- alu_wb_data  in  DATA_WIDTH  result
- mdu_wb_valid  in  1  MDU holds a result
- mdu_wb_ready  out  1  FIFO can accept an MDU result
- mdu_wb_rd  in  RD_WIDTH  destination register
- mdu_wb_data  in  DATA_WIDTH  result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  RD_WIDTH  write address (registered)
- rf_wdata  out  DATA_WIDTH  write data (registered)
- mdu_pending  out  2  FIFO occupancy 0..2, for hazard logic

## Operation
- MDU handshake: a result is pushed when mdu_wb_valid && mdu_wb_ready. mdu_wb_ready = !full, taken from registered occupancy. There is no same-cycle pop-through when full.
- Arbitration each cycle uses the FIFO head (h_valid = occupancy ≠ 0) and the ALU request.
  - starve_hit = h_valid && starve_cnt ≥ STARVE_LIMIT
  - grant_mdu = h_valid && (!alu_wb_valid || starve_hit)
  - alu_wb_ready = !starve_hit
  - grant_alu = alu_wb_valid && alu_wb_ready
- starve_cnt is 3 bits and saturates.
  - Cleared when grant_mdu or !h_valid.
  - Incremented when h_valid && grant_alu.
- Output register on the next edge:
  - On a grant, rf_we = (rd ≠ 0), and rf_waddr/rf_wdata load the winner's rd/data.
  - With no grant, rf_we = 0 and addr/data hold their value.
- Writes to x0 complete the handshake and consume the slot but never assert rf_we.
- The FIFO pops the head on grant_mdu. A push and pop in the same cycle keeps the occupancy unchanged.
- The upstream scoreboard guarantees that no two in-flight results share a nonzero rd. The arbiter does not resolve WAW ordering.

## Timing
- Reset (async assert, sync release) values: rf_we=0, rf_waddr=0, rf_wdata=0, occupancy 0, starve_cnt 0, mdu_pending=0, mdu_wb_ready=1.
- ALU result accepted in cycle N → rf_we high in cycle N+1.
- MDU result pushed in cycle N → eligible in N+1 → earliest rf_we in N+2.
- Worst-case MDU wait from eligibility is STARVE_LIMIT ALU wins, then a forced grant. During the forced cycle alu_wb_ready = 0.
- Reset mid-operation drops buffered results and any pending output write. No write reaches the register file after rst_n falls.
- The combinational paths are only alu_wb_ready and the grant logic, driven from registered state and alu_wb_valid. rf_* are pure flops.

## Configuration
- REGFILE_WB_ARB_STARVE_EN
  - Defined: the starvation counter and forced MDU grant behave as above.
  - Undefined: strict ALU priority. starve_hit is 0, alu_wb_ready is tied 1, and the counter is not built. The MDU can stall indefinitely under continuous ALU traffic.

## Structure
- Shared core package holds the wb_req_t typedef ({rd, data}), DATA_WIDTH/RD_WIDTH defaults and the REG_X0 constant.
- Sub-module wb_fifo2 is a 2-entry FIFO of wb_req_t with push/pop/full/occupancy.
- The arbiter, counter and output register live in regfile_wb_arb.

## Test plan
- Reset, then ALU writes rd=5, data=0x1234 alone → rf_we=1, rf_waddr=5, rf_wdata=0x1234 one cycle later. alu_wb_ready stays 1.
- MDU pushes rd=7, data=0xDEAD with the ALU idle → rf_we with waddr=7 two cycles after the push. mdu_pending goes 1→0.
- Continuous ALU valid with one MDU result waiting, STARVE_LIMIT=4 → four ALU writes, then alu_wb_ready=0 for one cycle and the MDU rd is written. ALU resumes next cycle. With the macro undefined, the MDU is never written.
- Three back-to-back MDU pushes while ALU busy → mdu_wb_ready drops after two, mdu_pending=2. The third is accepted only after the first pop.
- ALU write to rd=0 with data=0xFF → handshake completes, rf_we stays 0.
- rst_n asserted with the FIFO holding 2 entries → mdu_pending=0 and rf_we=0 immediately. No stale write appears after release.
